// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default reset vector.
package pc_seq_pkg;

    localparam int STATE_W              = 2;
    localparam int DEFAULT_RESET_VECTOR = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the sequencer: computes the fresh redirect target
// (jump beats branch) and the final candidate PC for a non-stalled cycle
// (fresh redirect > pending redirect > pc+1), each with an overflow flag.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic [PC_W-1:0] pc,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            pend_valid,
    input  logic [PC_W-1:0] pend_target,
    input  logic            pend_ovf,
    output logic            fresh_redirect,
    output logic [PC_W-1:0] fresh_target,
    output logic            fresh_ovf,
    output logic [PC_W-1:0] next_pc,
    output logic            next_ovf
);

    // Two guard bits make the branch sum's out-of-range cases visible:
    // anything non-zero above bit PC_W-1 means the true sum left 0..2^PC_W-1.
    logic [PC_W+1:0] branch_sum;
    logic [PC_W:0]   seq_sum;
    logic            branch_ovf;
    logic            seq_ovf;

    // Adders for the branch target and the sequential increment
    always_comb begin
        branch_sum = {2'b00, pc}
                   + {{(PC_W+1){1'b0}}, 1'b1}
                   + {{2{branch_offset[PC_W-1]}}, branch_offset};
        seq_sum    = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
        branch_ovf = (branch_sum[PC_W+1:PC_W] != 2'b00);
        seq_ovf    = seq_sum[PC_W];
    end

    // Priority mux: jump over branch for the fresh redirect, then fresh
    // redirect over pending redirect over sequential for the final choice
    always_comb begin
        fresh_redirect = jump | branch_taken;
        fresh_target   = branch_sum[PC_W-1:0];
        fresh_ovf      = branch_ovf;
        if (jump) begin
            fresh_target = jump_target;
            fresh_ovf    = 1'b0;
        end

        next_pc  = seq_sum[PC_W-1:0];
        next_ovf = seq_ovf;
        if (fresh_redirect) begin
            next_pc  = fresh_target;
            next_ovf = fresh_ovf;
        end else if (pend_valid) begin
            next_pc  = pend_target;
            next_ovf = pend_ovf;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller for the single-cycle core. Holds fetch invalid
// for a boot window after reset, then advances by +1, branch, or jump,
// holds on stall (capturing any redirect seen meanwhile), and halts stickily.
// Optional feature macro PC_BOUNDS_EN: an out-of-range increment or branch
// raises a sticky fault and halts with pc unchanged; otherwise pc wraps
// modulo 2^PC_W and fault is tied low.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W         = 6,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEFAULT_RESET_VECTOR),
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pend,
    output logic            fault
);

    localparam int              BOOT_W    = $clog2(BOOT_CYCLES + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    state_t            state;
    logic [BOOT_W-1:0] boot_cnt;
    logic [PC_W-1:0]   pend_target;
    logic              pend_ovf;

    logic              fresh_redirect;
    logic [PC_W-1:0]   fresh_target;
    logic              fresh_ovf;
    logic [PC_W-1:0]   next_pc;
    logic              next_ovf;

    pc_next_sel #(
        .PC_W (PC_W)
    ) u_next_sel (
        .pc             (pc),
        .jump           (jump),
        .jump_target    (jump_target),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .pend_valid     (redirect_pend),
        .pend_target    (pend_target),
        .pend_ovf       (pend_ovf),
        .fresh_redirect (fresh_redirect),
        .fresh_target   (fresh_target),
        .fresh_ovf      (fresh_ovf),
        .next_pc        (next_pc),
        .next_ovf       (next_ovf)
    );

`ifdef PC_BOUNDS_EN
    logic fault_reg;
    assign fault = fault_reg;
`else
    // Overflow only matters when bounds checking is built in
    logic unused_next_ovf;
    assign unused_next_ovf = next_ovf;
    assign fault = 1'b0;
`endif

    // Sequencer FSM with registered pc, pc_valid, pending redirect and fault.
    // A cycle with stall high in RUN or STALL holds pc and captures any
    // redirect; the first unstalled cycle applies fresh > pending > pc+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_BOOT;
            boot_cnt      <= '0;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            redirect_pend <= 1'b0;
            pend_target   <= '0;
            pend_ovf      <= 1'b0;
`ifdef PC_BOUNDS_EN
            fault_reg     <= 1'b0;
`endif
        end else if (enable) begin
            unique case (state)
                ST_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + BOOT_W'(1);
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (halt) begin
                        state         <= ST_HALT;
                        pc_valid      <= 1'b0;
                        redirect_pend <= 1'b0;
                    end else if (stall) begin
                        state    <= ST_STALL;
                        pc_valid <= 1'b0;
                        if (fresh_redirect) begin
                            redirect_pend <= 1'b1;
                            pend_target   <= fresh_target;
                            pend_ovf      <= fresh_ovf;
                        end
                    end else
`ifdef PC_BOUNDS_EN
                    if (next_ovf) begin
                        fault_reg     <= 1'b1;
                        state         <= ST_HALT;
                        pc_valid      <= 1'b0;
                        redirect_pend <= 1'b0;
                    end else
`endif
                    begin
                        state         <= ST_RUN;
                        pc            <= next_pc;
                        pc_valid      <= 1'b1;
                        redirect_pend <= 1'b0;
                    end
                end
                ST_HALT: begin
                    pc_valid      <= 1'b0;
                    redirect_pend <= 1'b0;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule
